// File: rtl/rx_iq_sample_fifo_if.sv
// I/Q sample FIFO bus: decimator-side capture inputs and consumer-side handshake/status.
// Optional DROP_CNT status signal is present when RX_IQ_DROP_CNT_EN is defined.
interface rx_iq_sample_fifo_if #(
  parameter int DATA_W = 19,
  parameter int AW     = 4
);
  logic                     SAMPLE_TICK;
  logic signed [DATA_W-1:0] I_IN;
  logic signed [DATA_W-1:0] Q_IN;
  logic                     OUT_READY;
  logic                     CLR_OVF;
  logic                     OUT_VALID;
  logic signed [DATA_W-1:0] I_OUT;
  logic signed [DATA_W-1:0] Q_OUT;
  logic [AW:0]              LEVEL;
  logic                     FULL;
  logic                     OVERFLOW;
`ifdef RX_IQ_DROP_CNT_EN
  logic [7:0]               DROP_CNT;
`endif

  modport master (
    output SAMPLE_TICK, I_IN, Q_IN, OUT_READY, CLR_OVF,
`ifdef RX_IQ_DROP_CNT_EN
    input  DROP_CNT,
`endif
    input  OUT_VALID, I_OUT, Q_OUT, LEVEL, FULL, OVERFLOW
  );

  modport slave (
    input  SAMPLE_TICK, I_IN, Q_IN, OUT_READY, CLR_OVF,
`ifdef RX_IQ_DROP_CNT_EN
    output DROP_CNT,
`endif
    output OUT_VALID, I_OUT, Q_OUT, LEVEL, FULL, OVERFLOW
  );
endinterface

// File: rtl/rx_iq_sample_fifo.sv
// First-word-fall-through FIFO capturing decimated I/Q pairs on each SAMPLE_TICK rising edge.
// Define RX_IQ_DROP_CNT_EN to add the saturating dropped-sample counter (DROP_CNT).
module rx_iq_sample_fifo #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              CLK,
  input  logic              RST,
  rx_iq_sample_fifo_if.slave bus
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic              tick_d;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level;
  logic              overflow;
  logic [DATA_W-1:0] mem_i [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic push_req;
  logic pop;
  logic push;
  logic drop;
  logic full;
  logic [AW:0] level_nxt;

  assign full     = (level == FULL_LVL);
  assign push_req = bus.SAMPLE_TICK & ~tick_d;
  assign pop      = (level != '0) & bus.OUT_READY;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + (AW+1)'(1);
      2'b01:   level_nxt = level - (AW+1)'(1);
      default: level_nxt = level;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tick_d   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      tick_d <= bus.SAMPLE_TICK;
      level  <= level_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (drop)             overflow <= 1'b1;
      else if (bus.CLR_OVF) overflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; outputs are masked to zero while empty instead.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_i[wr_ptr] <= bus.I_IN;
      mem_q[wr_ptr] <= bus.Q_IN;
    end
  end

  assign bus.OUT_VALID = (level != '0);
  assign bus.I_OUT     = bus.OUT_VALID ? mem_i[rd_ptr] : '0;
  assign bus.Q_OUT     = bus.OUT_VALID ? mem_q[rd_ptr] : '0;
  assign bus.LEVEL     = level;
  assign bus.FULL      = full;
  assign bus.OVERFLOW  = overflow;

`ifdef RX_IQ_DROP_CNT_EN
  logic [7:0] drop_cnt;

  // Clear and a coincident drop leave the count at one, matching the sticky flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      drop_cnt <= '0;
    end else if (bus.CLR_OVF) begin
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign bus.DROP_CNT = drop_cnt;
`endif
endmodule

// File: doc/rx_iq_sample_fifo.md
Name: rx_iq_sample_fifo

Overview:
- Sits directly downstream of the MIMO receive top. It consumes the 19-bit signed decimated I/Q samples (half-band output) and buffers them for the baseband processor.
- Runs on the fast receive clock CLK and detects each new sample by watching the decimated sample clock level (SAMPLE_TICK).
- Captures each I/Q pair into a FIFO and presents it over a valid/ready handshake.
- Tracks fill level and overflow.

Parameters:
- DATA_W, 19, width of each I and Q sample (signed).
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- AW, 4, address width; equals log2(DEPTH).

Ports:
- CLK  input  1  receive clock; all logic is on its rising edge.
- RST  input  1  reset, asynchronous assert, active-low.
- SAMPLE_TICK  input  1  decimated sample-clock level, synchronous to CLK (divided from it).
- I_IN  input  DATA_W  signed I sample from decimation.
- Q_IN  input  DATA_W  signed Q sample from decimation.
- OUT_READY  input  1  consumer accepts the head entry.
- CLR_OVF  input  1  one-cycle clear of OVERFLOW.
- OUT_VALID  output  1  FIFO not empty; head entry valid.
- I_OUT  output  DATA_W  head I sample.
- Q_OUT  output  DATA_W  head Q sample.
- LEVEL  output  AW+1  number of stored entries, 0..DEPTH.
- FULL  output  1  LEVEL == DEPTH.
- OVERFLOW  output  1  sticky; a sample was dropped.

Behaviour:
- Reset (RST low, asynchronous):
  - Write pointer, read pointer and LEVEL go to 0.
  - OUT_VALID=0, FULL=0, OVERFLOW=0.
  - I_OUT and Q_OUT read 0; memory contents are don't-care, but outputs are forced to 0 while empty.
  - The tick history register resets to 1, so a SAMPLE_TICK already high at reset release does not produce a capture.
- Edge detect:
  - tick_d <= SAMPLE_TICK every cycle.
  - push_req = SAMPLE_TICK & ~tick_d, a one-cycle pulse on each rising edge.
  - I_IN and Q_IN are sampled in the push_req cycle. They are stable there because decimation updates on the same divided-clock edge.
- Push/pop:
  - pop = OUT_VALID & OUT_READY.
  - push = push_req & (~FULL | pop). A simultaneous pop frees the slot, so a push into a full FIFO with pop active is accepted.
- Level update:
  - push only: LEVEL+1.
  - pop only: LEVEL-1.
  - push and pop together: LEVEL unchanged, both pointers advance.
- Pointers: AW bits, wrap DEPTH-1 -> 0. Full and empty are derived from LEVEL, not pointer equality.
- Output path (first-word-fall-through):
  - OUT_VALID = (LEVEL != 0).
  - I_OUT and Q_OUT show the entry at the read pointer.
  - Latency: a push at edge k into an empty FIFO gives OUT_VALID=1 and the data visible in the cycle after edge k.
  - I_OUT and Q_OUT must hold stable while OUT_VALID=1 and OUT_READY=0.
- Overflow:
  - push_req while FULL and no pop: the sample is dropped, the FIFO is unchanged, and OVERFLOW is set at that edge.
  - CLR_OVF clears OVERFLOW.
  - If a drop and CLR_OVF occur in the same cycle, set wins.
- Pop while empty is ignored; OUT_READY is don't-care when OUT_VALID=0.
- Data is stored bit-exact; no arithmetic or resizing.
- Reset asserted mid-transfer empties the FIFO immediately. No partial state survives.

Optional Feature:
- Macro: RX_IQ_DROP_CNT_EN.
- Defined:
  - Adds output port DROP_CNT [7:0], which counts dropped samples.
  - Saturates at 255, resets to 0, and clears together with OVERFLOW on CLR_OVF.
  - If a drop and CLR_OVF coincide, DROP_CNT becomes 1.
- Undefined: no DROP_CNT port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset release with SAMPLE_TICK held 1 -> no capture; LEVEL=0, OUT_VALID=0. Next rising edge with I_IN=19'sh12345, Q_IN=-5 -> one cycle later OUT_VALID=1, I_OUT=19'sh12345, Q_OUT=-5.
- OUT_READY=0, 16 tick edges with I=1..16 -> LEVEL=16, FULL=1, OVERFLOW=0. Then OUT_READY=1 -> outputs 1..16 in order, and LEVEL returns to 0.
- FIFO full, 17th edge with OUT_READY=0 -> OVERFLOW=1, LEVEL stays 16, sample dropped. Drained sequence is still 1..16.
- FIFO full, tick edge in the same cycle as a pop -> push accepted, LEVEL stays 16, no OVERFLOW; the new sample appears last.
- OVERFLOW=1, then CLR_OVF coinciding with another drop -> OVERFLOW stays 1. CLR_OVF alone next cycle -> 0. With RX_IQ_DROP_CNT_EN: 300 drops -> DROP_CNT=255.
- LEVEL=5, RST pulsed low between CLK edges -> outputs go to 0 immediately. After release -> LEVEL=0, and the read/write pointers restart so the next sample is read back correctly.
